// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one synchronous FIFO write port among NUM_REQ requesters.
// A grant is held for up to BURST accepted words. Writes stall while the FIFO reports full.
module fifo_wr_arbiter #(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 4,
    parameter int BURST   = 4,
    parameter int BURST_W = 3,
    parameter int IDX_W   = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [NUM_REQ-1:0]       i_req,
    input  logic [NUM_REQ*WIDTH-1:0] i_req_data,
    output logic [NUM_REQ-1:0]       o_ack,
    output logic [NUM_REQ-1:0]       o_gnt,
    input  logic                     i_fifo_full,
    output logic                     o_fifo_wr,
    output logic [WIDTH-1:0]         o_fifo_data,
    output logic                     o_busy
);

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    state_t               r_state;
    state_t               w_state_nx;
    logic [NUM_REQ-1:0]   r_gnt;
    logic [NUM_REQ-1:0]   w_gnt_nx;
    logic [IDX_W-1:0]     r_gidx;
    logic [IDX_W-1:0]     w_gidx_nx;
    logic [IDX_W-1:0]     r_last;
    logic [IDX_W-1:0]     w_last_nx;
    logic [BURST_W-1:0]   r_cnt;
    logic [BURST_W-1:0]   w_cnt_nx;
    logic [IDX_W-1:0]     w_base;
    logic [IDX_W-1:0]     w_pick;
    logic                 w_found;
    logic                 w_busy;
    logic                 w_xfer;
    logic                 w_release;

    assign w_busy    = (r_state == ST_BUSY);
    assign w_xfer    = w_busy & i_req[r_gidx] & ~i_fifo_full;
    assign w_release = w_busy & (~i_req[r_gidx] |
                                 (w_xfer & (r_cnt == BURST_W'(BURST - 1))));

    // While busy the current owner becomes lowest priority for the hand-over pick.
    assign w_base = w_busy ? r_gidx : r_last;

    always_comb begin
        logic [IDX_W-1:0] idx;
        w_pick  = '0;
        w_found = 1'b0;
        idx     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = IDX_W'((int'(w_base) + k) % NUM_REQ);
            if (!w_found && i_req[idx]) begin
                w_pick  = idx;
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_gnt_nx   = r_gnt;
        w_gidx_nx  = r_gidx;
        w_last_nx  = r_last;
        w_cnt_nx   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nx = ST_BUSY;
                    w_gnt_nx   = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_pick;
                    w_gidx_nx  = w_pick;
                    w_cnt_nx   = '0;
                end
            end
            ST_BUSY: begin
                if (w_release) begin
                    w_last_nx = r_gidx;
                    w_cnt_nx  = '0;
                    if (w_found) begin
                        w_gnt_nx  = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_pick;
                        w_gidx_nx = w_pick;
                    end else begin
                        w_state_nx = ST_IDLE;
                        w_gnt_nx   = '0;
                    end
                end else if (w_xfer) begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_gnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_gidx  <= '0;
            r_last  <= IDX_W'(NUM_REQ - 1);
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_gnt   <= w_gnt_nx;
            r_gidx  <= w_gidx_nx;
            r_last  <= w_last_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    // Reset forces the write side quiet even before the registers have cleared.
    assign o_fifo_wr   = w_xfer & ~i_rst;
    assign o_busy      = w_busy & ~i_rst;
    assign o_ack       = r_gnt & {NUM_REQ{o_fifo_wr}};
    assign o_gnt       = r_gnt;
    assign o_fifo_data = w_busy ? i_req_data[r_gidx*WIDTH +: WIDTH] : '0;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: a cycle-level round-robin reference model predicts
// grants and FIFO writes, and a negedge monitor compares every write the DUT presents.
module tb_fifo_wr_arbiter;

    localparam int WIDTH   = 8;
    localparam int NUM_REQ = 4;
    localparam int BURST   = 4;

    logic                     clk;
    logic                     rst;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] reqData;
    logic [NUM_REQ-1:0]       ack;
    logic [NUM_REQ-1:0]       gnt;
    logic                     fifoFull;
    logic                     fifoWr;
    logic [WIDTH-1:0]         fifoData;
    logic                     busy;

    fifo_wr_arbiter #(
        .WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .BURST(BURST), .BURST_W(3), .IDX_W(2)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_req_data(reqData),
        .o_ack(ack), .o_gnt(gnt), .i_fifo_full(fifoFull), .o_fifo_wr(fifoWr),
        .o_fifo_data(fifoData), .o_busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         idx;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;
    int   cycleNo = 0;

    // Reference model: owner (-1 when idle), words taken this grant, last served requester.
    int   mOwner = -1;
    int   mCnt = 0;
    int   mLast = NUM_REQ - 1;
    int   lastAckIdx = -1;

    bit         reqOn[NUM_REQ];
    logic [5:0] word[NUM_REQ];
    logic [3:0] mask = 4'b0000;
    int raisePct = 100;
    int dropPct = 0;
    int fullPct = 0;
    int rstPerMil = 0;
    bit forceRst = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d actual %0h required %0h", name, cycleNo, act, expv);
        end
    endtask

    function automatic int pickRr(input logic [NUM_REQ-1:0] r, input int last);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (r[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
        end
        return -1;
    endfunction

    function automatic logic [7:0] wordData(input int i);
        logic [1:0] ib;
        ib = 2'(i);
        return {ib, word[i]};
    endfunction

    task automatic applyStimulus();
        logic [3:0] expGnt;
        bit         xfer;
        int         g;
        exp_t       e;
        @(posedge clk);
        #1;
        cycleNo++;
        if (lastAckIdx >= 0) word[lastAckIdx]++;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!mask[i])
                reqOn[i] = 1'b0;
            else if (reqOn[i] && lastAckIdx != i)
                reqOn[i] = ($urandom_range(99) >= dropPct);
            else if (reqOn[i])
                reqOn[i] = ($urandom_range(99) >= dropPct);
            else
                reqOn[i] = ($urandom_range(99) < raisePct);
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            req[i] = reqOn[i];
            reqData[i*WIDTH +: WIDTH] = wordData(i);
        end
        rst      = forceRst || ($urandom_range(999) < rstPerMil);
        fifoFull = ($urandom_range(99) < fullPct);
        #1;
        expGnt = (mOwner >= 0) ? (4'b0001 << mOwner) : 4'b0000;
        checkOutput("gnt", 32'(gnt), 32'(expGnt));
        checkOutput("busy", 32'(busy), 32'((mOwner >= 0) && !rst));
        lastAckIdx = -1;
        if (rst) begin
            mOwner = -1;
            mCnt   = 0;
            mLast  = NUM_REQ - 1;
        end else if (mOwner < 0) begin
            if (req != 0) begin
                mOwner = pickRr(req, mLast);
                mCnt   = 0;
            end
        end else begin
            g    = mOwner;
            xfer = req[g] && !fifoFull;
            if (xfer) begin
                e.idx  = g;
                e.data = wordData(g);
                e.cyc  = cycleNo;
                expQ.push_back(e);
                lastAckIdx = g;
            end
            if (!req[g] || (xfer && mCnt == BURST - 1)) begin
                mLast  = g;
                mOwner = pickRr(req, g);
                mCnt   = 0;
            end else if (xfer) begin
                mCnt++;
            end
        end
    endtask

    // Monitor: consumes the expected-write queue whenever the DUT writes to the FIFO.
    always @(negedge clk) begin
        exp_t e;
        if (fifoWr === 1'b1) begin
            checkOutput("noWriteWhileFull", 32'(fifoFull), 32'd0);
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpectedWrite cycle %0d actual data %0h ack %b required no write",
                         cycleNo, fifoData, ack);
            end else begin
                e = expQ.pop_front();
                checkOutput("wrCycle", 32'(cycleNo), 32'(e.cyc));
                checkOutput("wrData", 32'(fifoData), 32'(e.data));
                checkOutput("wrAck", 32'(ack), 32'(4'b0001 << e.idx));
            end
        end else begin
            checkOutput("ackIdle", 32'(ack), 32'd0);
            if (expQ.size() > 0 && expQ[0].cyc <= cycleNo) begin
                e = expQ.pop_front();
                checks++;
                errors++;
                $display("[TB] FAIL missingWrite cycle %0d actual no write required data %0h from req %0d",
                         cycleNo, e.data, e.idx);
            end
        end
    end

    task automatic runPhase(input logic [3:0] m, input int raise, input int drop,
                            input int full, input int rstMil, input int cycles);
        mask      = m;
        raisePct  = raise;
        dropPct   = drop;
        fullPct   = full;
        rstPerMil = rstMil;
        for (int c = 0; c < cycles; c++) applyStimulus();
    endtask

    initial begin
        rst      = 1'b1;
        req      = '0;
        reqData  = '0;
        fifoFull = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            reqOn[i] = 1'b0;
            word[i]  = 6'(i * 8);
        end
        repeat (2) @(posedge clk);
        #1;
        checkOutput("resetGnt", 32'(gnt), 32'd0);
        checkOutput("resetBusy", 32'(busy), 32'd0);
        checkOutput("resetWr", 32'(fifoWr), 32'd0);
        rst = 1'b0;

        $display("[TB] sole requester 0, bursts re-granted");
        runPhase(4'b0001, 100, 0, 0, 0, 12);
        runPhase(4'b0000, 100, 0, 0, 0, 3);
        $display("[TB] all four requesters held");
        runPhase(4'b1111, 100, 0, 0, 0, 40);
        $display("[TB] requester 2 with full stalls");
        runPhase(4'b0100, 100, 0, 40, 0, 30);
        $display("[TB] reset in the middle of a burst");
        runPhase(4'b1000, 100, 0, 0, 0, 6);
        forceRst = 1'b1;
        runPhase(4'b1000, 100, 0, 0, 0, 1);
        forceRst = 1'b0;
        runPhase(4'b1001, 100, 0, 0, 0, 10);
        $display("[TB] requester drops mid burst");
        runPhase(4'b1010, 100, 30, 0, 0, 60);
        $display("[TB] random traffic");
        for (int blk = 0; blk < 40; blk++) begin
            runPhase(4'($urandom_range(15)), 50, 10, 25, 3, 200);
        end
        runPhase(4'b0000, 100, 0, 0, 0, 5);
        checkOutput("queueDrained", 32'(expQ.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
